// File: rtl/led_breathe.sv
// Breathing LED driver: ramps PWM brightness up, holds, ramps down, holds, forever.
// The duty register reloads only at PWM period boundaries, so a period never glitches mid-way.
module led_breathe #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 195312,
  parameter int HOLD_STEPS  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic [1:0]          phase,
  output logic                cycle_done
);

  localparam int PS_W = $clog2(STEP_CYCLES);
  localparam int HC_W = $clog2(HOLD_STEPS + 1);

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LEVEL_MIN = '0;
  localparam logic [PS_W-1:0]     PS_LAST   = PS_W'(STEP_CYCLES - 1);
  localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HIGH = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LOW  = 2'd3
  } phase_t;

  phase_t              r_phase;
  phase_t              w_phase_nxt;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic [HC_W-1:0]     r_hold_cnt;
  logic [HC_W-1:0]     w_hold_nxt;
  logic                r_cycle_done;
  logic                w_done_nxt;

  logic [PS_W-1:0]     r_prescaler;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty_active;
  logic                r_led;

  logic w_clear;
  logic w_step_tick;

  // Dropping en behaves exactly like reset so a new breath always starts dark.
  assign w_clear     = rst | ~en;
  assign w_step_tick = (r_prescaler == PS_LAST);

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_prescaler <= '0;
    end else if (w_step_tick) begin
      r_prescaler <= '0;
    end else begin
      r_prescaler <= r_prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_phase      <= RAMP_UP;
      r_level      <= '0;
      r_hold_cnt   <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_level      <= w_level_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_cycle_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    w_level_nxt = r_level;
    w_hold_nxt  = r_hold_cnt;
    w_done_nxt  = 1'b0;
    if (w_step_tick) begin
      case (r_phase)
        RAMP_UP: begin
          if (r_level == LEVEL_MAX) begin
            w_phase_nxt = HOLD_HIGH;
            w_hold_nxt  = '0;
          end else begin
            w_level_nxt = r_level + 1'b1;
          end
        end
        HOLD_HIGH: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_phase_nxt = RAMP_DOWN;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        RAMP_DOWN: begin
          if (r_level == LEVEL_MIN) begin
            w_phase_nxt = HOLD_LOW;
            w_hold_nxt  = '0;
          end else begin
            w_level_nxt = r_level - 1'b1;
          end
        end
        HOLD_LOW: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_phase_nxt = RAMP_UP;
            w_done_nxt  = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
        default: begin
          w_phase_nxt = RAMP_UP;
        end
      endcase
    end
  end

  // PWM: duty latches the pre-step level when a step and a period end coincide.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_pwm_cnt     <= '0;
      r_duty_active <= '0;
      r_led         <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == LEVEL_MAX) begin
        r_duty_active <= r_level;
      end
      r_led <= en & (r_pwm_cnt < r_duty_active);
    end
  end

  assign led        = r_led;
  assign level      = r_level;
  assign phase      = r_phase;
  assign cycle_done = r_cycle_done;

endmodule

// File: doc/led_breathe.md
# led_breathe

PWM "breathing" LED driver: the next output stage after the board clock buffer in the LED examples. In place of a hard on/off toggle, it ramps LED brightness linearly up, holds, ramps down and holds, forever, using an internal step prescaler and a PWM generator. It runs on the buffered single-ended fabric clock and drives one LED pin directly. It also exposes the current brightness level and phase for debug or ILA probing.

## Interface
- PWM_BITS, 8: PWM and brightness resolution N; LEVEL_MAX = 2^N-1; legal 2..16
- STEP_CYCLES, 195312: clock cycles per brightness step; legal >= 2
- HOLD_STEPS, 64: steps spent at full and at zero brightness; legal >= 1
- clk  input  1  buffered fabric clock; all logic on its rising edge
- rst  input  1  reset, synchronous and active-high; the only reset
- en  input  1  run enable; 0 = restart-and-hold-dark
- led  output  1  registered LED drive
- level  output  PWM_BITS  current brightness target, 0..LEVEL_MAX
- phase  output  2  FSM state: 0 RAMP_UP, 1 HOLD_HIGH, 2 RAMP_DOWN, 3 HOLD_LOW
- cycle_done  output  1  one-cycle pulse at the end of each full breath

## Operation
- **Reset (rst=1 on an edge):** led=0, level=0, phase=RAMP_UP, cycle_done=0. Internal registers also clear: prescaler=0, hold_cnt=0, pwm_cnt=0, duty_active=0. rst overrides en.
- **en=0 (rst=0):** same register state as reset, applied every cycle, so deasserting en mid-breath restarts from level 0 in RAMP_UP.
- **Prescaler:** counts 0..STEP_CYCLES-1 while en=1, then wraps to 0. step_tick is combinational, true when prescaler==STEP_CYCLES-1.
- **FSM:** updates only on step_tick.
  - RAMP_UP: if level==LEVEL_MAX, go to HOLD_HIGH with hold_cnt=0; else level+1.
  - HOLD_HIGH: if hold_cnt==HOLD_STEPS-1, go to RAMP_DOWN; else hold_cnt+1.
  - RAMP_DOWN: if level==0, go to HOLD_LOW with hold_cnt=0; else level-1.
  - HOLD_LOW: if hold_cnt==HOLD_STEPS-1, go to RAMP_UP and pulse cycle_done; else hold_cnt+1.
  - level never wraps. hold_cnt is ceil(log2(HOLD_STEPS+1)) bits.
- **PWM counter:** pwm_cnt is N bits and free-runs 0..LEVEL_MAX with natural wrap while en=1.
- **Glitch-free duty update:** duty_active loads level only on the cycle pwm_cnt==LEVEL_MAX, so duty changes only at PWM period boundaries.
- **LED drive:** led <= en & (pwm_cnt < duty_active), an unsigned N-bit compare. Duty d gives exactly d high cycles per 2^N-cycle period. LEVEL_MAX gives 2^N-1 of 2^N, never solid on; 0 gives solid off.

## Timing
- level and phase change on the edge at which step_tick is true, i.e. one cycle after prescaler reaches STEP_CYCLES-1.
- The first step_tick after reset or en rising occurs STEP_CYCLES cycles after the first cycle with en=1.
- Steps per breath = 2*(LEVEL_MAX+1+HOLD_STEPS); clocks per breath = STEP_CYCLES times that.
- cycle_done is high exactly one cycle, on the same edge as phase 3→0.
- A level change reaches led no sooner than the next PWM period boundary plus 1 cycle, and no later than 2^N+1 cycles after it.
- led lags the pwm_cnt/duty_active compare by 1 register stage.
- **Simultaneous events:** a step_tick on the same cycle as pwm_cnt==LEVEL_MAX loads the old level into duty_active; the new level applies from the next period.

## Test plan
Unless stated, benches use PWM_BITS=3, STEP_CYCLES=4, HOLD_STEPS=2 (LEVEL_MAX=7, 20 steps = 80 clocks per breath).
- **Reset/enable:** rst=1 for 3 cycles, then rst=0, en=0 for 20 cycles → led=0, level=0, phase=0, cycle_done=0 throughout.
- **Full breath trace:** en=1 → level 0..7 in RAMP_UP (one step per 4 clocks), then phase 1 for 2 steps, 7..0 in phase 2, then phase 3 for 2 steps. cycle_done pulses exactly once, 80 clocks after en rose, and every 80 clocks after that.
- **PWM duty:** when level is held at 5, each 8-cycle led window has exactly 5 ones, contiguous. At level 0 led stays 0; at level 7 each 8-cycle window has 7 ones.
- **Glitch-free update:** align step_tick mid-PWM-period → current period's high count matches the old duty; next period's matches the new duty.
- **Mid-operation abort:** drop en during RAMP_DOWN at level 4 → next cycle level=0, phase=0, led=0. Re-raise en → first step_tick after 4 clocks, level becomes 1. Repeat with rst=1 while en=1 → same result.
- **Default-parameter smoke:** PWM_BITS=8, STEP_CYCLES=2, HOLD_STEPS=1 → no level wrap at 255/0; cycle_done period = 2*(256+1)*2 = 1028 clocks.
